usb_tx_arbiter: RTL and testbench

- Shares the single USB transmit path (line driver OE and serializer input) among several answer generators: ACK/handshake, device descriptor, config descriptor, and so on.
- Waits for the bus to go idle, then enforces the inter-packet gap, grants exactly one requester, holds the grant until that requester signals done, and guards every grant with a bit-time timeout.
- Sits between the PID/setup analyzer's answer generators and the NRZI/bit-stuff transmitter.

---
 rtl/usb_tx_pkg.sv | 19 +
 rtl/usb_tx_prio_pick.sv | 53 +++++
 rtl/usb_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_usb_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit-path arbiter: FSM encoding, default timing, requester slots.
package usb_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GAP   = 2'd1,
      ST_ARB   = 2'd2,
      ST_GRANT = 2'd3
   } usb_tx_state_e;

   localparam int DEF_GAP_BITS     = 4;
   localparam int DEF_MAX_PKT_BITS = 1100;

   localparam int REQ_ACK  = 0;
   localparam int REQ_DESC = 1;
   localparam int REQ_CFG  = 2;
   localparam int REQ_IFEP = 3;

endpackage

// File: rtl/usb_tx_prio_pick.sv
// Combinational winner selection: requester 0 always wins; the rest are fixed-priority,
// or rotate after the last granted index when USB_TX_RR_EN is defined.
module usb_tx_prio_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
`ifdef USB_TX_RR_EN
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
   output logic [NUM_REQ-1:0]         onehot,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int IDX_W = $clog2(NUM_REQ);

`ifdef USB_TX_RR_EN
   always_comb begin : pick_rr
      logic found;
      int   pos;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      pos    = 0;
      if (req[0]) begin
         onehot[0] = 1'b1;
         found     = 1'b1;
      end
      // Positions 0..NUM_REQ-2 map to indices 1..NUM_REQ-1; the slot after ptr is position ptr.
      for (int k = 0; k < NUM_REQ - 1; k++) begin
         pos = (int'(ptr) + k) % (NUM_REQ - 1);
         if (!found && req[pos+1]) begin
            onehot[pos+1] = 1'b1;
            idx           = IDX_W'(pos + 1);
            found         = 1'b1;
         end
      end
   end
`else
   always_comb begin : pick_fixed
      logic found;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
            found     = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/usb_tx_arbiter.sv
// USB transmit-path arbiter: wait for idle bus, enforce the inter-packet gap, hold one grant until done.
// Optional USB_TX_RR_EN rotates priority among requesters 1..NUM_REQ-1.
module usb_tx_arbiter
   import usb_tx_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int GAP_BITS     = DEF_GAP_BITS,
   parameter int MAX_PKT_BITS = DEF_MAX_PKT_BITS,
   parameter int CNT_W        = $clog2(MAX_PKT_BITS + 1)
) (
   input  logic                       useClk,
   input  logic                       resetN,
   input  logic                       checkData,
   input  logic                       busIdle,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         done,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grantIdx,
   output logic                       txOE,
   output logic                       busy,
   output logic                       timeoutErr,
   output usb_tx_state_e              state_dbg
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);
   localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(MAX_PKT_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_PKT_BITS);

   usb_tx_state_e      state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
   logic [NUM_REQ-1:0] grant_nxt, pick_onehot;
   logic [IDX_W-1:0]   idx_nxt, pick_idx;
   logic               oe_nxt, tmo_nxt, drop;
`ifdef USB_TX_RR_EN
   logic [IDX_W-1:0]   ptr, ptr_nxt;
`endif

   usb_tx_prio_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req),
`ifdef USB_TX_RR_EN
      .ptr    (ptr),
`endif
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   assign cnt_inc   = (cnt >= CNT_SAT) ? cnt : cnt + CNT_W'(1);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant_nxt = grant;
      idx_nxt   = grantIdx;
      oe_nxt    = txOE;
      tmo_nxt   = 1'b0;
      drop      = 1'b0;
`ifdef USB_TX_RR_EN
      ptr_nxt   = ptr;
`endif
      case (state)
         ST_IDLE: begin
            if ((req != '0) && busIdle) begin
               state_nxt = ST_GAP;
               cnt_nxt   = '0;
            end
         end
         ST_GAP: begin
            if (req == '0) begin
               state_nxt = ST_IDLE;
            end else if (!busIdle) begin
               cnt_nxt = '0;
            end else if (checkData) begin
               if (cnt == GAP_LAST) state_nxt = ST_ARB;
               else                 cnt_nxt   = cnt_inc;
            end
         end
         ST_ARB: begin
            if (req == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_GRANT;
               grant_nxt = pick_onehot;
               idx_nxt   = pick_idx;
               oe_nxt    = 1'b1;
               cnt_nxt   = '0;
`ifdef USB_TX_RR_EN
               if (pick_idx != '0) ptr_nxt = pick_idx;
`endif
            end
         end
         ST_GRANT: begin
            // done beats a same-strobe timeout; a withdrawn request is a silent abort.
            if (done[grantIdx] || !req[grantIdx]) begin
               drop = 1'b1;
            end else if (checkData) begin
               if (cnt == PKT_LAST) begin
                  drop    = 1'b1;
                  tmo_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (drop) begin
         state_nxt = ST_GAP;
         grant_nxt = '0;
         oe_nxt    = 1'b0;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge useClk or negedge resetN) begin
      if (!resetN) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         grant      <= '0;
         grantIdx   <= '0;
         txOE       <= 1'b0;
         busy       <= 1'b0;
         timeoutErr <= 1'b0;
`ifdef USB_TX_RR_EN
         ptr        <= '0;
`endif
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         grant      <= grant_nxt;
         grantIdx   <= idx_nxt;
         txOE       <= oe_nxt;
         busy       <= (state_nxt != ST_IDLE);
         timeoutErr <= tmo_nxt;
`ifdef USB_TX_RR_EN
         ptr        <= ptr_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Build with USB_TX_RR_EN defined to exercise the rotating-priority variant.
module tb_usb_tx_arbiter;
   import usb_tx_pkg::*;

   localparam int NUM_REQ  = 4;
   localparam int GAP_BITS = 4;
   localparam int MAX_PKT  = 16;

   logic               useClk = 1'b0;
   logic               resetN = 1'b0;
   logic               checkData = 1'b0;
   logic               busIdle = 1'b0;
   logic [NUM_REQ-1:0] req = '0;
   logic [NUM_REQ-1:0] done = '0;
   logic [NUM_REQ-1:0] grant;
   logic [1:0]         grantIdx;
   logic               txOE, busy, timeoutErr;
   usb_tx_state_e      state_dbg;

   int checks = 0;
   int fails  = 0;

   usb_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .GAP_BITS(GAP_BITS), .MAX_PKT_BITS(MAX_PKT)
   ) dut (
      .useClk(useClk), .resetN(resetN), .checkData(checkData), .busIdle(busIdle),
      .req(req), .done(done), .grant(grant), .grantIdx(grantIdx), .txOE(txOE),
      .busy(busy), .timeoutErr(timeoutErr), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 useClk = ~useClk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: who owns the line, how many quiet bit times seen, bits sent
   int m_owner   = -1;
   bit m_waiting = 0;
   bit m_decide  = 0;
   int m_quiet   = 0;
   int m_bits    = 0;
   bit m_tmo     = 0;
   int m_last    = 0;

   function automatic int winner(input logic [NUM_REQ-1:0] r);
`ifdef USB_TX_RR_EN
      int j;
      if (r[0]) return 0;
      j = m_last;
      for (int k = 0; k < NUM_REQ - 1; k++) begin
         j = (j % (NUM_REQ - 1)) + 1;
         if (r[j]) return j;
      end
      return 0;
`else
      for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
      return 0;
`endif
   endfunction

   always @(posedge useClk or negedge resetN) begin
      if (!resetN) begin
         m_owner = -1; m_waiting = 0; m_decide = 0;
         m_quiet = 0; m_bits = 0; m_tmo = 0; m_last = 0;
      end else begin
         m_tmo = 0;
         if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner]) begin
               m_owner = -1; m_waiting = 1; m_quiet = 0;
            end else if (checkData) begin
               m_bits++;
               if (m_bits == MAX_PKT) begin
                  m_tmo = 1; m_owner = -1; m_waiting = 1; m_quiet = 0;
               end
            end
         end else if (m_decide) begin
            m_decide = 0;
            if (req != '0) begin
               m_owner = winner(req);
               m_bits  = 0;
               if (m_owner != 0) m_last = m_owner;
            end
         end else if (m_waiting) begin
            if (req == '0) m_waiting = 0;
            else if (!busIdle) m_quiet = 0;
            else if (checkData) begin
               m_quiet++;
               if (m_quiet == GAP_BITS) begin
                  m_decide = 1; m_waiting = 0;
               end
            end
         end else if ((req != '0) && busIdle) begin
            m_waiting = 1; m_quiet = 0;
         end
      end
   end

   // per-cycle compare against the model
   initial begin
      @(posedge useClk);
      forever begin
         @(negedge useClk);
         check("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("txOE", 32'(txOE), 32'(m_owner >= 0));
         check("busy", 32'(busy), 32'((m_owner >= 0) || m_waiting || m_decide));
         check("timeoutErr", 32'(timeoutErr), 32'(m_tmo));
         if (m_owner >= 0) check("grantIdx", 32'(grantIdx), 32'(m_owner));
      end
   end

   // driver tasks
   task automatic bit_time();
      @(negedge useClk) checkData = 1'b1;
      @(negedge useClk) checkData = 1'b0;
      @(negedge useClk);
   endtask

   // Last gap strobe: grant must still be low one clock later and high two clocks later.
   task automatic final_strobe(input logic [NUM_REQ-1:0] exp_mask, input string name);
      @(negedge useClk) checkData = 1'b1;
      @(negedge useClk) checkData = 1'b0;
      check({name, "_lat1"}, 32'(grant), 32'd0);
      @(negedge useClk);
      check({name, "_lat2"}, 32'(grant), 32'(exp_mask));
      check({name, "_oe"}, 32'(txOE), 32'd1);
   endtask

   task automatic get_grant(input logic [NUM_REQ-1:0] exp_mask, input string name);
      repeat (GAP_BITS - 1) bit_time();
      final_strobe(exp_mask, name);
   endtask

   task automatic pulse_done(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] new_req);
      @(negedge useClk) begin done = mask; req = new_req; end
      @(negedge useClk) done = '0;
   endtask

   logic [NUM_REQ-1:0] rr_exp [4];

   initial begin
      busIdle = 1'b1;
      repeat (3) @(negedge useClk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_oe", 32'(txOE), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_idx", 32'(grantIdx), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      resetN = 1'b1;

      // single request, done pulse
      @(negedge useClk) req = 4'b0001;
      get_grant(4'b0001, "single");
      pulse_done(4'b0001, 4'b0000);
      check("single_drop", 32'(grant), 32'd0);
      repeat (2) @(negedge useClk);

      // priority: ACK arrives mid-gap and wins, then a full gap before the next grant
      req = 4'b0110;
      repeat (2) bit_time();
      req = 4'b0111;
      bit_time();
      final_strobe(4'b0001, "prio_ack");
      pulse_done(4'b0001, 4'b0110);
      repeat (GAP_BITS - 1) bit_time();
      check("post_pkt_gap", 32'(grant), 32'd0);
      final_strobe(4'b0010, "prio_next");
      pulse_done(4'b0010, 4'b0000);
      repeat (2) @(negedge useClk);

      // bus activity restarts the gap count
      req = 4'b0100;
      repeat (2) bit_time();
      busIdle = 1'b0;
      repeat (2) bit_time();
      busIdle = 1'b1;
      repeat (GAP_BITS - 1) bit_time();
      check("gap_restart", 32'(grant), 32'd0);
      final_strobe(4'b0100, "bus_busy");
      pulse_done(4'b0100, 4'b0000);
      repeat (2) @(negedge useClk);

      // timeout on the MAX_PKT-th strobe
      req = 4'b0010;
      get_grant(4'b0010, "tmo_grant");
      repeat (MAX_PKT - 1) bit_time();
      check("pre_timeout", 32'(grant), 32'b0010);
      @(negedge useClk) checkData = 1'b1;
      @(negedge useClk) checkData = 1'b0;
      check("tmo_pulse", 32'(timeoutErr), 32'd1);
      check("tmo_drop", 32'(grant), 32'd0);
      @(negedge useClk);
      check("tmo_single", 32'(timeoutErr), 32'd0);
      // done on the same strobe as the timeout: no error
      get_grant(4'b0010, "tmo_regrant");
      repeat (MAX_PKT - 1) bit_time();
      @(negedge useClk) begin checkData = 1'b1; done = 4'b0010; end
      @(negedge useClk) begin checkData = 1'b0; done = '0; req = '0; end
      check("done_beats_tmo", 32'(timeoutErr), 32'd0);
      check("done_tmo_drop", 32'(grant), 32'd0);
      repeat (2) @(negedge useClk);

      // abort by withdrawing the request
      req = 4'b0100;
      get_grant(4'b0100, "abort_grant");
      repeat (2) bit_time();
      @(negedge useClk) req = '0;
      @(negedge useClk);
      check("abort_drop", 32'(grant), 32'd0);
      check("abort_no_err", 32'(timeoutErr), 32'd0);
      repeat (2) @(negedge useClk);

      // asynchronous reset mid-grant
      req = 4'b1000;
      get_grant(4'b1000, "rst_grant_pre");
      @(negedge useClk);
      #2 resetN = 1'b0;
      #1;
      check("arst_grant", 32'(grant), 32'd0);
      check("arst_oe", 32'(txOE), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge useClk) req = '0;
      @(negedge useClk) resetN = 1'b1;
      repeat (2) @(negedge useClk);

      // repeated grants with requesters 1..3 held
`ifdef USB_TX_RR_EN
      rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0010;
`else
      rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0010; rr_exp[3] = 4'b0010;
`endif
      req = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         get_grant(rr_exp[i], "rotate");
         pulse_done(rr_exp[i], (i == 3) ? 4'b0000 : 4'b1110);
      end
      repeat (3) @(negedge useClk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
